// File: rtl/display_arb_pkg.sv
// Shared types and slice helpers for the display arbiter.
// The per-client slice helpers take vectors widened to the largest legal client count.
package display_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Index width for a client count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [15:0] data_slice(input logic [16*MAX_REQ-1:0] vec,
                                             input logic [MAX_IDX_W-1:0]  idx);
    return vec[{idx, 4'b0000} +: 16];
  endfunction

  function automatic logic [3:0] dp_slice(input logic [4*MAX_REQ-1:0] vec,
                                          input logic [MAX_IDX_W-1:0] idx);
    return vec[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
  import display_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  int         dist_s;
  int         best_dist_s;
  logic       take_s;

  // Smallest rotation distance from start among the active requests wins.
  always_comb begin
    best_dist_s = NUM_REQ;
    winner_idx  = '0;
    dist_s      = 0;
    take_s      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s      = (i + NUM_REQ - int'(start)) % NUM_REQ;
      take_s      = req[i] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      winner_idx  = take_s ? IDX_W'(i) : winner_idx;
    end
  end

  // One-hot form of the winning index, qualified by any request present.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      winner[i] = valid && (winner_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum on-screen hold time.
// Define DISPLAY_ARB_OWNER_DP_EN to show the owner index on dp instead of dp_in.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MIN_HOLD = 500000,
  parameter int HOLD_W   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] data,
  input  logic [4*NUM_REQ-1:0]  dp_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic [3:0]            hex0,
  output logic [3:0]            hex1,
  output logic [3:0]            hex2,
  output logic [3:0]            hex3,
  output logic [3:0]            dp,
  output logic                  busy
);

  localparam int                IDX_W    = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  arb_state_e          state_r, state_nxt_s;
  logic [NUM_REQ-1:0]  grant_r, grant_nxt_s;
  logic [IDX_W-1:0]    last_owner_r, last_owner_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
  logic [15:0]         digits_r, digits_nxt_s;
  logic [3:0]          dp_r, dp_nxt_s;
  logic                busy_r, busy_nxt_s;

  logic [IDX_W-1:0]    start_s, load_idx_s, pick_idx_s;
  logic [NUM_REQ-1:0]  pick_onehot_s;
  logic                pick_valid_s;
  logic                hold_done_s, owner_req_s, others_s, load_s;
  logic [16*MAX_REQ-1:0] data_ext_s;
  logic [MAX_IDX_W-1:0]  load_idx_ext_s;

  // Widen client vectors so the package helpers can index them uniformly.
  always_comb begin
    data_ext_s                     = '0;
    data_ext_s[16*NUM_REQ-1:0]     = data;
    load_idx_ext_s                 = '0;
    load_idx_ext_s[IDX_W-1:0]      = load_idx_s;
  end

  // The search always starts just past the current/last owner.
  always_comb begin
    start_s     = (last_owner_r == LAST_IDX) ? '0 : last_owner_r + IDX_W'(1);
    hold_done_s = (hold_cnt_r == HOLD_MAX);
    owner_req_s = |(req & grant_r);
    others_s    = |(req & ~grant_r);
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .start      (start_s),
    .winner     (pick_onehot_s),
    .winner_idx (pick_idx_s),
    .valid      (pick_valid_s)
  );

  // Ownership FSM: grant, hand-off, hold counting and load control.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_owner_nxt_s = last_owner_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    busy_nxt_s       = busy_r;
    load_s           = 1'b0;
    load_idx_s       = last_owner_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s      = OWN;
          grant_nxt_s      = pick_onehot_s;
          last_owner_nxt_s = pick_idx_s;
          hold_cnt_nxt_s   = '0;
          busy_nxt_s       = 1'b1;
          load_s           = 1'b1;
          load_idx_s       = pick_idx_s;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = '0;
          busy_nxt_s  = 1'b0;
        end
      end
      OWN: begin
        // Release or rotate once the hold has elapsed; a pending request means a direct hand-off.
        if (hold_done_s && (!owner_req_s || others_s)) begin
          if (pick_valid_s) begin
            grant_nxt_s      = pick_onehot_s;
            last_owner_nxt_s = pick_idx_s;
            hold_cnt_nxt_s   = '0;
            load_s           = 1'b1;
            load_idx_s       = pick_idx_s;
          end else begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
            busy_nxt_s  = 1'b0;
          end
        end else begin
          hold_cnt_nxt_s = hold_done_s ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
          load_s         = owner_req_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = '0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

`ifdef DISPLAY_ARB_OWNER_DP_EN
  logic [3:0] owner_ext_s;
  logic       unused_dp_s;
  assign unused_dp_s = ^dp_in;

  // Digits follow the owner's data; dp shows who owns the display.
  always_comb begin
    owner_ext_s                = '0;
    owner_ext_s[IDX_W-1:0]     = last_owner_nxt_s;
    digits_nxt_s = load_s ? data_slice(data_ext_s, load_idx_ext_s) : digits_r;
    dp_nxt_s     = busy_nxt_s ? owner_ext_s : 4'b0000;
  end
`else
  logic [4*MAX_REQ-1:0] dp_ext_s;

  // Digits and decimal points both follow the owner's inputs, frozen when not loading.
  always_comb begin
    dp_ext_s                  = '0;
    dp_ext_s[4*NUM_REQ-1:0]   = dp_in;
    digits_nxt_s = load_s ? data_slice(data_ext_s, load_idx_ext_s) : digits_r;
    dp_nxt_s     = load_s ? dp_slice(dp_ext_s, load_idx_ext_s) : dp_r;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_owner_r <= LAST_IDX;
      hold_cnt_r   <= '0;
      digits_r     <= 16'h0000;
      dp_r         <= 4'b0000;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      digits_r     <= digits_nxt_s;
      dp_r         <= dp_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;
  assign dp    = dp_r;
  assign hex0  = digits_r[3:0];
  assign hex1  = digits_r[7:4];
  assign hex2  = digits_r[11:8];
  assign hex3  = digits_r[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (NUM_REQ=4, MIN_HOLD=4) with a behavioural model.
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data;
  logic [15:0] dp_in;
  logic [3:0]  grant;
  logic [3:0]  hex0, hex1, hex2, hex3, dp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  display_arbiter #(.NUM_REQ(N), .MIN_HOLD(MH), .HOLD_W(20)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .dp_in(dp_in),
    .grant(grant), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner;   // -1 when nobody owns the display
  int          m_last;
  int          m_age;     // edges since the granting edge
  logic [15:0] m_disp;
  logic [3:0]  m_dp;

  function automatic int rr_after(input int from, input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  task automatic m_load(input int w);
    logic [63:0] d;
    logic [15:0] p;
    d      = data >> (16 * w);
    p      = dp_in >> (4 * w);
    m_disp = d[15:0];
    m_dp   = p[3:0];
  endtask

  task automatic m_take(input int w);
    m_owner = w;
    m_last  = w;
    m_age   = 0;
    m_load(w);
  endtask

  initial begin
    m_owner = -1; m_last = N - 1; m_age = 0; m_disp = 16'h0000; m_dp = 4'b0000;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_owner = -1; m_last = N - 1; m_age = 0; m_disp = 16'h0000; m_dp = 4'b0000;
      end else if (m_owner < 0) begin
        int w;
        w = rr_after(m_last, req);
        if (w >= 0) m_take(w);
      end else begin
        bit mine, others, done;
        int w;
        done   = (m_age >= MH);
        mine   = ((req >> m_owner) & 4'b0001) != 4'b0000;
        others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
        if (done && (!mine || others)) begin
          w = rr_after(m_owner, req);
          if (w >= 0) m_take(w);
          else m_owner = -1;
        end else begin
          m_age++;
          if (mine) m_load(m_owner);
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        logic [3:0] exp_dp;
`ifdef DISPLAY_ARB_OWNER_DP_EN
        exp_dp = (m_owner < 0) ? 4'b0000 : m_owner[3:0];
`else
        exp_dp = m_dp;
`endif
        chk("m_grant", {28'd0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("m_busy", {31'd0, busy}, (m_owner < 0) ? 32'd0 : 32'd1);
        chk("m_hex", {16'd0, hex3, hex2, hex1, hex0}, {16'd0, m_disp});
        chk("m_dp", {28'd0, dp}, {28'd0, exp_dp});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; req = 4'b0000; data = 64'd0; dp_in = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'd0);
    chk("rst_dp", {28'd0, dp}, 32'd0);
    reset = 1'b0;

    // single client
    req = 4'b0010; data[31:16] = 16'hBEEF; dp_in[7:4] = 4'b0100;
    @(negedge clk);
    chk("single_grant", {28'd0, grant}, 32'h2);
    chk("single_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'hBEEF);
`ifdef DISPLAY_ARB_OWNER_DP_EN
    chk("single_dp", {28'd0, dp}, 32'h1);
`else
    chk("single_dp", {28'd0, dp}, 32'h4);
`endif
    chk("single_busy", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    repeat (6) @(negedge clk);
    chk("release_grant", {28'd0, grant}, 32'd0);
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'hBEEF);

    // asynchronous reset while owning
    req = 4'b0001; data[15:0] = 16'h1234;
    repeat (2) @(negedge clk);
    chk("pre_rst_grant", {28'd0, grant}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_grant", {28'd0, grant}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'd0);
    chk("async_rst_dp", {28'd0, dp}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("regrant", {28'd0, grant}, 32'h1);
    chk("regrant_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h1234);

    // early drop, nobody else waiting
    @(negedge clk);
    req = 4'b0000; data[15:0] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("drop_hold_grant", {28'd0, grant}, 32'h1);
    chk("drop_hold_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h1234);
    @(negedge clk);
    chk("drop_idle_grant", {28'd0, grant}, 32'd0);
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);
    chk("drop_idle_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h1234);

    // early drop with client 2 waiting: direct hand-off
    req = 4'b0001; data[15:0] = 16'h5555; data[47:32] = 16'hABCD;
    @(negedge clk);
    chk("h_grant0", {28'd0, grant}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    chk("h_grant_hold", {28'd0, grant}, 32'h1);
    chk("h_hex_frozen", {16'd0, hex3, hex2, hex1, hex0}, 32'h5555);
    @(negedge clk);
    chk("h_grant2", {28'd0, grant}, 32'h4);
    chk("h_busy", {31'd0, busy}, 32'd1);
    chk("h_hex2", {16'd0, hex3, hex2, hex1, hex0}, 32'hABCD);

    // rotation with all four requesting
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b1111;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      chk("rot_grant", {28'd0, grant}, 32'd1 << ((i / 5) % 4));
    end

    // capture and stay
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b0001; data = 64'd0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("stay_grant", {28'd0, grant}, 32'h1);
      chk("stay_hex", {16'd0, hex3, hex2, hex1, hex0}, i - 1);
      data[15:0] = 16'(i);
    end

`ifdef DISPLAY_ARB_OWNER_DP_EN
    // owner index on dp
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b0100;
    @(negedge clk);
    chk("odp_granted", {28'd0, dp}, 32'h2);
    req = 4'b0000;
    repeat (6) @(negedge clk);
    chk("odp_idle_dp", {28'd0, dp}, 32'h0);
    chk("odp_idle_grant", {28'd0, grant}, 32'h0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
